// File: rtl/mux4to1_rr_merge_pkg.sv
// Shared constants and output-stage state encoding for the 4-to-1 round-robin merge.
package mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_EMPTY = 1'b0;
  localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/mux4to1_rr_merge_if.sv
// Bundle of the four input channels and the merged output stream.
interface mux4to1_rr_merge_if
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux4to1_rr_merge_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping 3->0.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt     = '0;
    gnt_idx = ptr;
    any     = |req;
    found   = 1'b0;
    idx     = ptr;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux4to1_rr_merge.sv
// Four-channel round-robin merge with a single registered output stage.
module mux4to1_rr_merge
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  mux4to1_rr_merge_if.slave  bus
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic              can_load;
  logic              load;
  logic [N_CH-1:0]   gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;

  // Holding rst_n low blocks grants so nothing is accepted while resetting.
  assign can_load = rst_n & ((state_q == ST_EMPTY) | bus.out_ready);

  rr_arbiter4 u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .en      (can_load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign load        = any & can_load;
  assign bus.in_ready = gnt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      // A load during a drain simply overwrites the departing beat.
      data_d  = bus.in_data[gnt_idx*DATA_W +: DATA_W];
      sel_d   = gnt_idx;
      state_d = ST_FULL;
      ptr_d   = gnt_idx + SEL_W'(1);
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux4to1_rr_merge.sv
// Self-checking bench: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_mux4to1_rr_merge;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4to1_rr_merge_if #(.DATA_W(8)) bus ();

  mux4to1_rr_merge #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which channel is favoured next, and what the output register holds.
  int         rr_next;
  bit         holding;
  logic [7:0] held_data;
  int         held_ch;
  int         mdl_gnt;
  bit         mdl_ro;
  logic [31:0] mdl_d;

  // Demux-side scoreboard: expected words per channel, in acceptance order.
  logic [7:0] exp_q [4][$];

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    bit          ro;
    logic [3:0]  rdy;
    bit          ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int model_grant(input logic [3:0] v, input bit ro);
    if (holding && !ro) return -1;
    for (int o = 0; o < 4; o++) begin
      int ch;
      ch = (rr_next + o) % 4;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic apply(input logic [3:0] v, input logic [31:0] d, input bit ro);
    logic [3:0] exp_rdy;
    int ch;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ro;
    mdl_ro = ro;
    mdl_d  = d;
    #1;
    mdl_gnt = model_grant(v, ro);
    exp_rdy = (mdl_gnt < 0) ? 4'b0000 : 4'(1 << mdl_gnt);
    check("model_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("model_out_valid", 32'(bus.out_valid), 32'(holding));
    if (holding) begin
      check("model_out_data", 32'(bus.out_data), 32'(held_data));
      check("model_out_sel", 32'(bus.out_sel), 32'(held_ch));
    end
    if (bus.out_valid && ro) begin
      ch = int'(bus.out_sel);
      check("demux_has_pending", 32'(exp_q[ch].size() > 0), 32'd1);
      if (exp_q[ch].size() > 0)
        check($sformatf("demux_ch%0d_order", ch), 32'(bus.out_data), 32'(exp_q[ch].pop_front()));
    end
    for (int k = 0; k < 4; k++)
      if (v[k] && bus.in_ready[k]) exp_q[k].push_back(d[k*8 +: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (mdl_gnt >= 0) begin
      holding   = 1'b1;
      held_data = mdl_d[mdl_gnt*8 +: 8];
      held_ch   = mdl_gnt;
      rr_next   = (mdl_gnt + 1) % 4;
    end else if (holding && mdl_ro) begin
      holding = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int n, input logic [3:0] v, input bit ro);
    rst_n         = 1'b0;
    bus.in_valid  = v;
    bus.in_data   = '0;
    bus.out_ready = ro;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_sel", 32'(bus.out_sel), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    end
    rst_n   = 1'b1;
    holding = 1'b0;
    rr_next = 0;
    mdl_gnt = -1;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tbl[2] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0};
    tbl[3] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    tbl[4] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tbl[5] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tbl[6] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tbl[7] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[8] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[9] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    mdl_gnt = -1;
    holding = 1'b0;
    rr_next = 0;

    // Reset held two cycles with every channel requesting.
    do_reset(2, 4'hF, 1'b1);

    // Vector table: single channel, drain, rotation from a wrapped pointer, stall.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].ro);
      check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
        check($sformatf("tbl%0d_out_sel", i), 32'(bus.out_sel), 32'(tbl[i].os));
      end
      tick();
    end

    // All channels valid from pointer 0: sel 0,1,2,3,0 with no bubble.
    do_reset(1, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      apply(4'hF, 32'h1312_1110, 1'b1);
      if (i == 0) check("rr_first_ready", 32'(bus.in_ready), 32'h1);
      if (i >= 1) begin
        check($sformatf("rr%0d_valid", i), 32'(bus.out_valid), 32'd1);
        check($sformatf("rr%0d_sel", i), 32'(bus.out_sel), 32'((i - 1) % 4));
        check($sformatf("rr%0d_data", i), 32'(bus.out_data), 32'(8'h10 + (i - 1) % 4));
      end
      tick();
    end

    // Backpressure: hold 3C/1 for five stalled cycles, then channel 2 is next.
    do_reset(1, 4'h0, 1'b1);
    apply(4'b0010, 32'h0000_3C00, 1'b1);
    check("bp_load_ready", 32'(bus.in_ready), 32'h2);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(4'b0110, 32'h0055_3C00, 1'b0);
      check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      check("bp_stall_data", 32'(bus.out_data), 32'h3C);
      check("bp_stall_sel", 32'(bus.out_sel), 32'd1);
      tick();
    end
    apply(4'b0110, 32'h0055_3C00, 1'b1);
    check("bp_release_ready", 32'(bus.in_ready), 32'h4);
    tick();

    // Pointer wrap: after a channel-2 grant, 1001 grants 3 then 0.
    do_reset(1, 4'h0, 1'b1);
    apply(4'b0100, 32'h0077_0000, 1'b1);
    tick();
    apply(4'b1001, 32'h9900_0088, 1'b1);
    check("wrap_first_ready", 32'(bus.in_ready), 32'h8);
    tick();
    apply(4'b1001, 32'h9900_0088, 1'b1);
    check("wrap_second_ready", 32'(bus.in_ready), 32'h1);
    check("wrap_out_sel", 32'(bus.out_sel), 32'd3);
    tick();

    // Reset while stalled discards the beat and returns the pointer to 0.
    do_reset(1, 4'h0, 1'b1);
    apply(4'b0001, 32'h0000_00EE, 1'b1);
    tick();
    apply(4'b0000, 32'h0, 1'b0);
    check("mid_stall_valid", 32'(bus.out_valid), 32'd1);
    tick();
    do_reset(1, 4'b0000, 1'b0);
    apply(4'b1010, 32'h4400_3300, 1'b1);
    check("post_rst_ready", 32'(bus.in_ready), 32'h2);
    tick();
    apply(4'b0000, 32'h0, 1'b1);
    check("post_rst_sel", 32'(bus.out_sel), 32'd1);
    check("post_rst_data", 32'(bus.out_data), 32'h33);
    tick();

    // Random traffic with intermittent backpressure against the model.
    do_reset(1, 4'h0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      apply(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, 32'h0, 1'b1);
      tick();
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("drain_ch%0d_empty", k), 32'(exp_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
